// File: rtl/ecpri_pkg.sv
// Shared constants, field offsets and FSM state type for the eCPRI RMA receive path.
package ecpri_pkg;

  localparam logic [15:0] ETH_TYPE_ECPRI = 16'hAEFE;
  localparam logic [7:0]  MSG_TYPE_RMA   = 8'h04;
  localparam logic [3:0]  ECPRI_REV      = 4'h1;

  localparam logic [3:0] RW_READ     = 4'h0;
  localparam logic [3:0] RW_WRITE    = 4'h1;
  localparam logic [3:0] RW_WRITE_NR = 4'h2;

  localparam logic [3:0] RMA_REQ  = 4'h0;
  localparam logic [3:0] RMA_RESP = 4'h1;

  localparam int unsigned ETH_HDR_LEN = 14;
  localparam int unsigned RMA_HDR_END = 30;

  // Byte offsets of individual header fields within the frame
  localparam logic [7:0] OFS_ETYPE_HI   = 8'd12;
  localparam logic [7:0] OFS_REV        = 8'd14;
  localparam logic [7:0] OFS_MSG        = 8'd15;
  localparam logic [7:0] OFS_PSIZE_HI   = 8'd16;
  localparam logic [7:0] OFS_PSIZE_LO   = 8'd17;
  localparam logic [7:0] OFS_RMA_ID     = 8'd18;
  localparam logic [7:0] OFS_RW         = 8'd19;
  localparam logic [7:0] OFS_ELEM_HI    = 8'd20;
  localparam logic [7:0] OFS_ELEM_LO    = 8'd21;
  localparam logic [7:0] OFS_ADDR_FIRST = 8'd22;
  localparam logic [7:0] OFS_ADDR_LAST  = 8'd27;
  localparam logic [7:0] OFS_LEN_HI     = 8'd28;
  localparam logic [7:0] OFS_LEN_LO     = 8'd29;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ETH,
    ST_ECPRI,
    ST_RMA,
    ST_PAYLOAD,
    ST_RESP,
    ST_DROP
  } rx_state_e;

endpackage

// File: rtl/ecpri_rx_byte_reader.sv
// Streams a frame out of the frame RAM: address counter, 1-cycle read pipeline,
// and a registered byte/index/valid output, one byte per cycle.
module ecpri_rx_byte_reader #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [7:0]            frame_len,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_en,
  output logic                  byte_vld,
  output logic [DATA_WIDTH-1:0] byte_data,
  output logic [7:0]            byte_idx
);

  logic [7:0] len_q;
  logic       pend_q;
  logic [7:0] pend_idx_q;
  logic       at_end_c;

  // rd_en stays high one cycle past the last address so its data is still driven
  assign at_end_c = (rd_addr == ADDR_WIDTH'(len_q));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_addr    <= '0;
      rd_en      <= 1'b0;
      len_q      <= '0;
      pend_q     <= 1'b0;
      pend_idx_q <= '0;
      byte_vld   <= 1'b0;
      byte_data  <= '0;
      byte_idx   <= '0;
    end else if (start) begin
      rd_addr  <= '0;
      rd_en    <= 1'b1;
      len_q    <= frame_len;
      pend_q   <= 1'b0;
      byte_vld <= 1'b0;
    end else begin
      byte_vld <= pend_q & ~abort;
      if (pend_q) begin
        byte_data <= rd_data;
        byte_idx  <= pend_idx_q;
      end
      pend_q     <= rd_en & ~abort & ~at_end_c;
      pend_idx_q <= 8'(rd_addr);
      if (abort || at_end_c)
        rd_en <= 1'b0;
      else if (rd_en)
        rd_addr <= rd_addr + ADDR_WIDTH'(1);
    end
  end

endmodule

// File: rtl/ecpri_rx_rma.sv
// eCPRI RMA receive parser: copies the Ethernet header, decodes the RMA request,
// stores write data and flags the TX side. Optional ECPRI_RX_ETYPE_CHECK_EN drops non-eCPRI EtherTypes.
module ecpri_rx_rma #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter logic [15:0] ETH_TYPE_ECPRI = ecpri_pkg::ETH_TYPE_ECPRI
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  recv_pkt,
  input  logic [7:0]            inp_data_fifo,
  output logic [ADDR_WIDTH-1:0] addr_1,
  inout  wire  [DATA_WIDTH-1:0] data_1,
  output logic                  we_1,
  output logic                  oe_1,
  output logic [ADDR_WIDTH-1:0] addr_0,
  inout  wire  [DATA_WIDTH-1:0] data_0,
  output logic                  we_0,
  output logic                  oe_0,
  output logic [ADDR_WIDTH-1:0] addr_2,
  inout  wire  [DATA_WIDTH-1:0] data_2,
  output logic                  we_2,
  output logic                  oe_2,
  output logic                  send_write_resp,
  output logic                  send_read_resp,
  output logic [7:0]            resp_payload_len
);

  import ecpri_pkg::*;

  rx_state_e             state;
  logic [7:0]            len_q;
  logic [7:0]            etype_hi_q;
  logic [15:0]           psize_q;
  logic [7:0]            rma_id_q;
  logic [3:0]            rw_q;
  logic [15:0]           elem_id_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [7:0]            l_hi_q;
  logic [7:0]            l_q;
  logic [DATA_WIDTH-1:0] hdr_wdata_q;
  logic [DATA_WIDTH-1:0] pay_wdata_q;

  logic                  byte_vld;
  logic [DATA_WIDTH-1:0] byte_data;
  logic [7:0]            byte_idx;

  logic       start_c;
  logic       abort_c;
  logic       rw_ok_c;
  logic       l_ok_c;
  logic       l_fit_c;
  logic [7:0] wr_room_c;
  logic [7:0] pay_ofs_c;

  assign we_1 = 1'b0;
  assign oe_0 = 1'b0;
  assign oe_2 = 1'b0;
  assign data_0 = we_0 ? hdr_wdata_q : {DATA_WIDTH{1'bz}};
  assign data_2 = we_2 ? pay_wdata_q : {DATA_WIDTH{1'bz}};

  assign start_c   = (state == ST_IDLE) && recv_pkt && (inp_data_fifo >= 8'(RMA_HDR_END));
  assign abort_c   = (state == ST_IDLE) || (state == ST_RESP) || (state == ST_DROP);
  assign rw_ok_c   = (byte_data[3:0] == RMA_REQ) &&
                     ((byte_data[7:4] == RW_READ) || (byte_data[7:4] == RW_WRITE) ||
                      (byte_data[7:4] == RW_WRITE_NR));
  assign wr_room_c = len_q - 8'(RMA_HDR_END);
  assign l_ok_c    = (l_hi_q == 8'd0);
  assign l_fit_c   = ({l_hi_q, 8'(byte_data)} <= {8'd0, wr_room_c});
  assign pay_ofs_c = byte_idx - 8'(RMA_HDR_END);

  ecpri_rx_byte_reader #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_reader (
    .clk       (clk),
    .reset     (reset),
    .start     (start_c),
    .abort     (abort_c),
    .frame_len (inp_data_fifo),
    .rd_data   (data_1),
    .rd_addr   (addr_1),
    .rd_en     (oe_1),
    .byte_vld  (byte_vld),
    .byte_data (byte_data),
    .byte_idx  (byte_idx)
  );

  // Frame parser FSM; every decision is taken on the byte currently presented by the reader
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= ST_IDLE;
      len_q            <= '0;
      etype_hi_q       <= '0;
      psize_q          <= '0;
      rma_id_q         <= '0;
      rw_q             <= '0;
      elem_id_q        <= '0;
      base_q           <= '0;
      l_hi_q           <= '0;
      l_q              <= '0;
      addr_0           <= '0;
      hdr_wdata_q      <= '0;
      we_0             <= 1'b0;
      addr_2           <= '0;
      pay_wdata_q      <= '0;
      we_2             <= 1'b0;
      send_write_resp  <= 1'b0;
      send_read_resp   <= 1'b0;
      resp_payload_len <= '0;
    end else begin
      we_0            <= 1'b0;
      we_2            <= 1'b0;
      send_write_resp <= 1'b0;
      send_read_resp  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (recv_pkt) begin
            len_q <= inp_data_fifo;
            state <= start_c ? ST_ETH : ST_DROP;
          end
        end
        ST_ETH: begin
          if (byte_vld) begin
            we_0        <= 1'b1;
            addr_0      <= ADDR_WIDTH'(byte_idx);
            hdr_wdata_q <= byte_data;
            if (byte_idx == OFS_ETYPE_HI)
              etype_hi_q <= 8'(byte_data);
            if (byte_idx == 8'(ETH_HDR_LEN - 1)) begin
`ifdef ECPRI_RX_ETYPE_CHECK_EN
              state <= ({etype_hi_q, 8'(byte_data)} == ETH_TYPE_ECPRI) ? ST_ECPRI : ST_DROP;
`else
              state <= ST_ECPRI;
`endif
            end
          end
        end
        ST_ECPRI: begin
          if (byte_vld) begin
            case (byte_idx)
              OFS_REV:      if (byte_data[7:4] != ECPRI_REV) state <= ST_DROP;
              OFS_MSG:      if (8'(byte_data) != MSG_TYPE_RMA) state <= ST_DROP;
              OFS_PSIZE_HI: psize_q[15:8] <= 8'(byte_data);
              OFS_PSIZE_LO: begin
                psize_q[7:0] <= 8'(byte_data);
                state        <= ST_RMA;
              end
              default: ;
            endcase
          end
        end
        ST_RMA: begin
          if (byte_vld) begin
            // Only the low ADDR_WIDTH bits of the 48-bit address survive the shift
            if ((byte_idx >= OFS_ADDR_FIRST) && (byte_idx <= OFS_ADDR_LAST))
              base_q <= ADDR_WIDTH'({base_q, byte_data});
            case (byte_idx)
              OFS_RMA_ID:  rma_id_q <= 8'(byte_data);
              OFS_RW: begin
                rw_q <= byte_data[7:4];
                if (!rw_ok_c) state <= ST_DROP;
              end
              OFS_ELEM_HI: elem_id_q[15:8] <= 8'(byte_data);
              OFS_ELEM_LO: elem_id_q[7:0]  <= 8'(byte_data);
              OFS_LEN_HI:  l_hi_q <= 8'(byte_data);
              OFS_LEN_LO: begin
                l_q <= 8'(byte_data);
                if (!l_ok_c || ((rw_q != RW_READ) && !l_fit_c))
                  state <= ST_DROP;
                else if ((rw_q == RW_READ) || (8'(byte_data) == 8'd0))
                  state <= ST_RESP;
                else
                  state <= ST_PAYLOAD;
              end
              default: ;
            endcase
          end
        end
        ST_PAYLOAD: begin
          if (byte_vld) begin
            we_2        <= 1'b1;
            addr_2      <= base_q + ADDR_WIDTH'(pay_ofs_c);
            pay_wdata_q <= byte_data;
            if (pay_ofs_c == (l_q - 8'd1))
              state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rw_q == RW_WRITE) begin
            send_write_resp  <= 1'b1;
            resp_payload_len <= '0;
          end else if (rw_q == RW_READ) begin
            send_read_resp   <= 1'b1;
            resp_payload_len <= l_q;
          end
          state <= ST_IDLE;
        end
        ST_DROP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Parsed fields kept for downstream use but not consumed by this block
`ifdef ECPRI_RX_ETYPE_CHECK_EN
  logic unused_c;
  assign unused_c = ^{psize_q, rma_id_q, elem_id_q};
`else
  logic unused_c;
  assign unused_c = ^{psize_q, rma_id_q, elem_id_q, etype_hi_q, ETH_TYPE_ECPRI};
`endif

endmodule

// File: tb/tb_ecpri_rx_rma.sv
// Directed bench for ecpri_rx_rma with behavioural models of the three RAMs.
module tb_ecpri_rx_rma;

  logic        clk = 1'b0;
  logic        reset;
  logic        recv_pkt;
  logic [7:0]  inp_data_fifo;
  logic [15:0] addr_0, addr_1, addr_2;
  wire  [7:0]  data_0, data_1, data_2;
  logic        we_0, we_1, we_2, oe_0, oe_1, oe_2;
  logic        send_write_resp, send_read_resp;
  logic [7:0]  resp_payload_len;

  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];
  logic [7:0] mem2 [65536];
  logic [7:0] rd1;
  int hw_cnt = 0, pw_cnt = 0, wr_cnt = 0, rd_cnt = 0;
  logic [7:0] last_rlen = 8'h00;
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  ecpri_rx_rma dut (
    .clk(clk), .reset(reset), .recv_pkt(recv_pkt), .inp_data_fifo(inp_data_fifo),
    .addr_1(addr_1), .data_1(data_1), .we_1(we_1), .oe_1(oe_1),
    .addr_0(addr_0), .data_0(data_0), .we_0(we_0), .oe_0(oe_0),
    .addr_2(addr_2), .data_2(data_2), .we_2(we_2), .oe_2(oe_2),
    .send_write_resp(send_write_resp), .send_read_resp(send_read_resp),
    .resp_payload_len(resp_payload_len)
  );

  assign data_1 = (oe_1 && !we_1) ? rd1 : 8'bz;

  always @(posedge clk) begin
    if (we_0) begin mem0[addr_0[7:0]] <= data_0; hw_cnt <= hw_cnt + 1; end
    if (we_2) begin mem2[addr_2] <= data_2; pw_cnt <= pw_cnt + 1; end
    if (oe_1 && !we_1) rd1 <= mem1[addr_1[7:0]];
    if (send_write_resp) wr_cnt <= wr_cnt + 1;
    if (send_read_resp) rd_cnt <= rd_cnt + 1;
    if (send_write_resp || send_read_resp) last_rlen <= resp_payload_len;
  end

  typedef struct {
    logic [15:0] etype;
    logic [7:0]  rev;
    logic [7:0]  mtype;
    logic [7:0]  rw;
    logic [47:0] addr;
    logic [15:0] l;
    logic [7:0]  len;
    int          exp_wr;
    int          exp_rd;
    logic [7:0]  exp_rlen;
    int          exp_pw;
    int          exp_hw;
  } vec_t;

  vec_t v [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [15:0] et, input logic [7:0] rev, input logic [7:0] mt,
                              input logic [7:0] rw, input logic [47:0] a, input logic [15:0] l,
                              input logic [7:0] len, input int ew, input int er,
                              input logic [7:0] erl, input int epw, input int ehw);
    vec_t r;
    r.etype = et; r.rev = rev; r.mtype = mt; r.rw = rw; r.addr = a; r.l = l; r.len = len;
    r.exp_wr = ew; r.exp_rd = er; r.exp_rlen = erl; r.exp_pw = epw; r.exp_hw = ehw;
    return r;
  endfunction

  function automatic logic [7:0] pat(input int k);
    logic [7:0] b;
    case (k % 4)
      0: b = 8'hDE;
      1: b = 8'hAD;
      2: b = 8'hBE;
      default: b = 8'hEF;
    endcase
    return b + 8'(k / 4);
  endfunction

  task automatic build_frame(input vec_t fv, input int seed);
    for (int i = 0; i < 256; i++) mem1[i] = 8'(i * 7 + seed * 13 + 1);
    mem1[12] = fv.etype[15:8];
    mem1[13] = fv.etype[7:0];
    mem1[14] = fv.rev;
    mem1[15] = fv.mtype;
    mem1[16] = 8'h00;
    mem1[17] = 8'(fv.l + 16'd12);
    mem1[18] = 8'(seed);
    mem1[19] = fv.rw;
    mem1[20] = 8'h12;
    mem1[21] = 8'h34;
    for (int j = 0; j < 6; j++) mem1[22 + j] = fv.addr[8 * (5 - j) +: 8];
    mem1[28] = fv.l[15:8];
    mem1[29] = fv.l[7:0];
    for (int k = 0; k < 226; k++) mem1[30 + k] = pat(k);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_addr1"}, 32'(addr_1), 32'h0);
    chk({tag, "_oe1"}, {31'd0, oe_1}, 32'h0);
    chk({tag, "_we"}, {29'd0, we_0, we_1, we_2}, 32'h0);
    chk({tag, "_addr0_2"}, {addr_0, addr_2}, 32'h0);
    chk({tag, "_pulses"}, {30'd0, send_write_resp, send_read_resp}, 32'h0);
    chk({tag, "_rlen"}, 32'(resp_payload_len), 32'h0);
    chk({tag, "_data0z"}, {24'd0, data_0}, {24'd0, 8'bz});
    chk({tag, "_data2z"}, {24'd0, data_2}, {24'd0, 8'bz});
  endtask

  task automatic run_vec(input vec_t fv, input int seed, input bit poke, input string tag);
    int hw0, pw0, wr0, rd0, bad;
    logic [15:0] a;
    build_frame(fv, seed);
    @(negedge clk);
    hw0 = hw_cnt; pw0 = pw_cnt; wr0 = wr_cnt; rd0 = rd_cnt;
    recv_pkt = 1'b1; inp_data_fifo = fv.len;
    @(negedge clk);
    recv_pkt = 1'b0; inp_data_fifo = 8'h00;
    if (poke) begin
      repeat (4) @(negedge clk);
      recv_pkt = 1'b1; inp_data_fifo = 8'd20;
      @(negedge clk);
      recv_pkt = 1'b0; inp_data_fifo = 8'h00;
    end
    repeat (int'(fv.len) + 12) @(negedge clk);
    chk({tag, "_wr_resp"}, 32'(wr_cnt - wr0), 32'(fv.exp_wr));
    chk({tag, "_rd_resp"}, 32'(rd_cnt - rd0), 32'(fv.exp_rd));
    chk({tag, "_pay_wr"}, 32'(pw_cnt - pw0), 32'(fv.exp_pw));
    chk({tag, "_hdr_wr"}, 32'(hw_cnt - hw0), 32'(fv.exp_hw));
    if (fv.exp_wr + fv.exp_rd > 0) chk({tag, "_rlen"}, 32'(last_rlen), 32'(fv.exp_rlen));
    if (fv.exp_hw > 0) begin
      bad = 0;
      for (int i = 0; i < 14; i++) if (mem0[i] !== mem1[i]) bad++;
      chk({tag, "_hdr_data"}, 32'(bad), 32'h0);
    end
    if (fv.exp_pw > 0) begin
      bad = 0;
      for (int k = 0; k < fv.exp_pw; k++) begin
        a = fv.addr[15:0] + 16'(k);
        if (mem2[a] !== pat(k)) bad++;
      end
      chk({tag, "_pay_data"}, 32'(bad), 32'h0);
    end
  endtask

  initial begin
    int pw0, wr0, rd0;
    vec_t rv;
    reset = 1'b0; recv_pkt = 1'b0; inp_data_fifo = 8'h00;
    #3;
    check_reset_outputs("por");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    //        etype     rev    type   rw     address             L       len    wr rd rlen  pw hw
    v[0]  = mk(16'hAEFE, 8'h10, 8'h04, 8'h10, 48'h0000_0000_0100, 16'd4,   8'd34, 1, 0, 8'h00, 4, 14);
    v[1]  = mk(16'hAEFE, 8'h10, 8'h04, 8'h00, 48'h0000_0000_0300, 16'd16,  8'd30, 0, 1, 8'h10, 0, 14);
    v[2]  = mk(16'hAEFE, 8'h10, 8'h04, 8'h20, 48'h0000_0000_0200, 16'd2,   8'd32, 0, 0, 8'h00, 2, 14);
    v[3]  = mk(16'hAEFE, 8'h10, 8'h00, 8'h10, 48'h0000_0000_0400, 16'd4,   8'd34, 0, 0, 8'h00, 0, 14);
    v[4]  = mk(16'hAEFE, 8'h20, 8'h04, 8'h10, 48'h0000_0000_0400, 16'd4,   8'd34, 0, 0, 8'h00, 0, 14);
    v[5]  = mk(16'hAEFE, 8'h10, 8'h04, 8'h10, 48'h0000_0000_0400, 16'd10,  8'd34, 0, 0, 8'h00, 0, 14);
    v[6]  = mk(16'hAEFE, 8'h10, 8'h04, 8'h10, 48'h0000_0000_0400, 16'd4,   8'd20, 0, 0, 8'h00, 0, 0);
    v[7]  = mk(16'hAEFE, 8'h10, 8'h04, 8'h00, 48'h0000_0000_0400, 16'h012C, 8'd30, 0, 0, 8'h00, 0, 14);
    v[8]  = mk(16'hAEFE, 8'h10, 8'h04, 8'h10, 48'h0000_0000_0500, 16'd0,   8'd30, 1, 0, 8'h00, 0, 14);
    v[9]  = mk(16'hAEFE, 8'h10, 8'h04, 8'h10, 48'h1234_5678_FFFE, 16'd4,   8'd34, 1, 0, 8'h00, 4, 14);
    v[10] = mk(16'hAEFE, 8'h10, 8'h04, 8'h30, 48'h0000_0000_0400, 16'd2,   8'd32, 0, 0, 8'h00, 0, 14);
    v[11] = mk(16'hAEFE, 8'h10, 8'h04, 8'h11, 48'h0000_0000_0400, 16'd2,   8'd32, 0, 0, 8'h00, 0, 14);
`ifdef ECPRI_RX_ETYPE_CHECK_EN
    v[12] = mk(16'h0800, 8'h10, 8'h04, 8'h10, 48'h0000_0000_0600, 16'd2,   8'd32, 0, 0, 8'h00, 0, 14);
`else
    v[12] = mk(16'h0800, 8'h10, 8'h04, 8'h10, 48'h0000_0000_0600, 16'd2,   8'd32, 1, 0, 8'h00, 2, 14);
`endif
    v[13] = mk(16'hAEFE, 8'h10, 8'h04, 8'h00, 48'h0000_0000_0000, 16'd255, 8'd30, 0, 1, 8'hFF, 0, 14);
    v[14] = mk(16'hAEFE, 8'h10, 8'h04, 8'h10, 48'h0000_0000_0700, 16'd10,  8'd40, 1, 0, 8'h00, 10, 14);
    v[15] = mk(16'hAEFE, 8'h10, 8'h04, 8'h20, 48'h0000_0000_0900, 16'd0,   8'd30, 0, 0, 8'h00, 0, 14);

    for (int i = 0; i < 16; i++) run_vec(v[i], i + 1, 1'b0, $sformatf("v%0d", i));

    // recv_pkt with a too-short length while busy must not disturb the frame
    rv = v[0]; rv.addr = 48'h0000_0000_0A00;
    run_vec(rv, 40, 1'b1, "busy");

    // asynchronous reset in the middle of a long payload
    rv = mk(16'hAEFE, 8'h10, 8'h04, 8'h10, 48'h0000_0000_0800, 16'd100, 8'd130, 0, 0, 8'h00, 0, 0);
    build_frame(rv, 50);
    @(negedge clk);
    pw0 = pw_cnt; wr0 = wr_cnt; rd0 = rd_cnt;
    recv_pkt = 1'b1; inp_data_fifo = rv.len;
    @(negedge clk);
    recv_pkt = 1'b0; inp_data_fifo = 8'h00;
    repeat (60) @(negedge clk);
    #2 reset = 1'b0;
    #1 check_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (150) @(negedge clk);
    chk("midrst_partial", {31'd0, (pw_cnt - pw0 > 0) && (pw_cnt - pw0 < 100)}, 32'h1);
    chk("midrst_pulses", 32'((wr_cnt - wr0) + (rd_cnt - rd0)), 32'h0);

    rv = v[0]; rv.addr = 48'h0000_0000_0B00;
    run_vec(rv, 60, 1'b0, "recover");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
